// File: rtl/risc_pkg.sv
// Shared types for the accumulator RISC core: opcodes, controller states, field layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_pkg;

   // Opcode occupies the top OPC_W bits of the instruction word.
   localparam int OPC_W = 3;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STA = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   // Bit index of the opcode LSB for a given data width.
   function automatic int opc_lsb(input int data_w);
      return data_w - OPC_W;
   endfunction

endpackage

// File: rtl/acc_alu.sv
// Accumulator ALU: ADD/AND/XOR/LDA result and ADD carry-out.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to commit the result.
//
// Ports: i_op opcode, i_acc current accumulator, i_operand memory word,
//        o_result next accumulator value, o_carry ADD carry-out (0 otherwise).
module acc_alu
   import risc_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  opcode_t            i_op,
   input  logic [DATA_W-1:0]  i_acc,
   input  logic [DATA_W-1:0]  i_operand,
   output logic [DATA_W-1:0]  o_result,
   output logic               o_carry
);

   logic [DATA_W:0] w_sum;

   assign w_sum = {1'b0, i_acc} + {1'b0, i_operand};

   always_comb begin
      o_result = i_acc;
      o_carry  = 1'b0;
      case (i_op)
         OP_ADD:  {o_carry, o_result} = w_sum;
         OP_AND:  o_result = i_acc & i_operand;
         OP_XOR:  o_result = i_acc ^ i_operand;
         OP_LDA:  o_result = i_operand;
         default: ;
      endcase
   end

endmodule

// File: rtl/acc_risc_core.sv
// Multicycle accumulator RISC core with one unified req/ready memory port.
// Latency: 2 cycles for HLT/SKZ/JMP, 3 for memory-operand ops, +1 per wait cycle.
// Backpressure: holds mem_req/we/addr/wdata stable until mem_ready; pc/acc/IR freeze meanwhile.
//
// Ports: clk, rst (async active-low); mem_req/mem_we/mem_addr/mem_wdata out,
//        mem_rdata/mem_ready in; pc, acc, carry, halted architectural status.
module acc_risc_core
   import risc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              carry,
   output logic              halted
);

   localparam int              OPC_LSB = opc_lsb(DATA_W);
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_ir;
   logic                r_carry;

   opcode_t             w_op;
   logic [ADDR_W-1:0]   w_opnd;
   logic [DATA_W-1:0]   w_alu_res;
   logic                w_alu_c;

   assign w_op   = opcode_t'(r_ir[DATA_W-1 -: OPC_W]);
   assign w_opnd = r_ir[ADDR_W-1:0];

   // Bits between the operand and the opcode carry no meaning.
   generate
      if (OPC_LSB > ADDR_W) begin : g_gap
         logic w_unused_ir;
         assign w_unused_ir = ^r_ir[OPC_LSB-1:ADDR_W];
      end
   endgenerate

   acc_alu #(.DATA_W(DATA_W)) u_alu (
      .i_op      (w_op),
      .i_acc     (r_acc),
      .i_operand (mem_rdata),
      .o_result  (w_alu_res),
      .o_carry   (w_alu_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_acc   <= '0;
         r_ir    <= '0;
         r_carry <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (mem_ready) begin
                  r_ir    <= mem_rdata;
                  r_pc    <= r_pc + PC_ONE;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               case (w_op)
                  OP_HLT: r_state <= ST_HALT;
                  OP_SKZ: begin
                     // pc already points past SKZ; one more skips the next word.
                     if (r_acc == '0) r_pc <= r_pc + PC_ONE;
                     r_state <= ST_FETCH;
                  end
                  OP_JMP: begin
                     r_pc    <= w_opnd;
                     r_state <= ST_FETCH;
                  end
                  default: r_state <= ST_MEM;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  if (w_op != OP_STA) r_acc   <= w_alu_res;
                  if (w_op == OP_ADD) r_carry <= w_alu_c;
                  r_state <= ST_FETCH;
               end
            end
            ST_HALT: ;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Request signals come only from registered state so ready never loops back.
   assign mem_req   = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign mem_we    = (r_state == ST_MEM) && (w_op == OP_STA);
   assign mem_addr  = (r_state == ST_MEM) ? w_opnd : r_pc;
   assign mem_wdata = r_acc;
   assign pc        = r_pc;
   assign acc       = r_acc;
   assign carry     = r_carry;
   assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_acc_risc_core.sv
// Scoreboard bench for acc_risc_core against an instruction-level reference model.
// Latency: n/a.
// Backpressure: memory ready driven tied-high, random, stalled on writes, or scripted.
module tb_acc_risc_core;

   localparam int DW = 16;
   localparam int AW = 8;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_req, mem_we, mem_ready, carry, halted;
   logic [AW-1:0] mem_addr, pc;
   logic [DW-1:0] mem_wdata, mem_rdata, acc;

   logic [DW-1:0] tb_mem [256];
   txn_t          exp_q [$];
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;
   int            rdy_sel = 0;
   logic          rnd_rdy = 1'b1;
   logic          man_rdy = 1'b0;
   int            cyc = 0;
   int            first_req = -1;
   int            halt_cyc = -1;

   always #5 clk = ~clk;

   acc_risc_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .pc(pc), .acc(acc), .carry(carry), .halted(halted)
   );

   assign mem_rdata = tb_mem[mem_addr];

   always_comb begin
      mem_ready = man_rdy;
      if (rdy_sel == 0)      mem_ready = 1'b1;
      else if (rdy_sel == 1) mem_ready = rnd_rdy;
      else if (rdy_sel == 2) mem_ready = !mem_we;
   end

   initial begin
      forever begin
         @(negedge clk);
         rnd_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", nm, got, req);
      end
   endtask

   function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] a);
      return {op, 5'b0, a};
   endfunction

   // Monitor: every completed transaction is checked against the next expected one.
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         #4;
         cyc++;
         if (rst && mem_req && first_req < 0) first_req = cyc;
         if (rst && halted && halt_cyc < 0)  halt_cyc = cyc;
         if (rst && mem_req && mem_ready) begin
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
            if (mon_en) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL txn_extra got we=%0b addr=%02h wdata=%04h required none",
                           mem_we, mem_addr, mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  if (mk(mem_we, mem_addr, mem_wdata) !== e) begin
                     errors++;
                     $display("FAIL txn got we=%0b addr=%02h wdata=%04h required we=%0b addr=%02h wdata=%04h",
                              mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                  end
               end
            end
         end
      end
   end

   // Instruction-level reference: emits the bus transactions the program must produce.
   task automatic model_run(input int max_i, output logic [DW-1:0] m_acc, output logic m_c,
                            output logic [AW-1:0] m_pc, output bit m_halt);
      logic [DW-1:0] mm [256];
      logic [DW-1:0] ir;
      logic [AW-1:0] a;
      logic [DW:0]   s;
      logic [2:0]    op;
      for (int i = 0; i < 256; i++) mm[i] = tb_mem[i];
      m_acc = '0; m_c = 1'b0; m_pc = '0; m_halt = 1'b0;
      for (int n = 0; n < max_i && !m_halt; n++) begin
         exp_q.push_back(mk(1'b0, m_pc, m_acc));
         ir = mm[m_pc];
         m_pc = m_pc + 8'd1;
         a  = ir[AW-1:0];
         op = ir[DW-1:DW-3];
         if (op == 3'd0) m_halt = 1'b1;
         else if (op == 3'd1) begin
            if (m_acc == 0) m_pc = m_pc + 8'd1;
         end else if (op == 3'd7) m_pc = a;
         else begin
            exp_q.push_back(mk(op == 3'd6, a, m_acc));
            case (op)
               3'd2: begin s = {1'b0, m_acc} + {1'b0, mm[a]}; m_acc = s[DW-1:0]; m_c = s[DW]; end
               3'd3: m_acc = m_acc & mm[a];
               3'd4: m_acc = m_acc ^ mm[a];
               3'd5: m_acc = mm[a];
               default: mm[a] = m_acc;
            endcase
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #4;
   endtask

   task automatic step(input logic r);
      @(negedge clk);
      man_rdy = r;
      #4;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mon_en = 1'b0;
      exp_q.delete();
      tick();
   endtask

   task automatic run_prog(input int sel, input int max_i, input string nm);
      logic [DW-1:0] m_acc;
      logic          m_c;
      logic [AW-1:0] m_pc;
      bit            m_halt;
      int            n;
      model_run(max_i, m_acc, m_c, m_pc, m_halt);
      rdy_sel = sel;
      first_req = -1;
      halt_cyc = -1;
      mon_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         tick();
         n++;
      end
      mon_en = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout got=%0d pending required=0", nm, exp_q.size());
         exp_q.delete();
      end else if (m_halt) begin
         repeat (3) tick();
         check({nm, "_halted"}, 32'(halted), 32'd1);
         check({nm, "_pc"},     32'(pc),     32'(m_pc));
         check({nm, "_acc"},    32'(acc),    32'(m_acc));
         check({nm, "_carry"},  32'(carry),  32'(m_c));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] wd0;
      rst = 1'b0;
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tick();
      check("rst_req",    32'(mem_req),  32'd0);
      check("rst_pc",     32'(pc),       32'd0);
      check("rst_acc",    32'(acc),      32'd0);
      check("rst_halted", 32'(halted),   32'd0);
      check("rst_addr",   32'(mem_addr), 32'd0);

      // Reset during a stalled STA memory phase.
      do_reset();
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tb_mem[0] = ins(3'd5, 8'h10); tb_mem[1] = ins(3'd2, 8'h11); tb_mem[2] = ins(3'd6, 8'h12);
      tb_mem[8'h10] = 16'h1234; tb_mem[8'h11] = 16'hFFFF;
      rdy_sel = 2;
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 50 && !(mem_req && mem_we); n++) tick();
      check("t1_sta_stall", 32'({mem_req, mem_we}), 32'h3);
      check("t1_acc_pre",   32'(acc),   32'h1233);
      check("t1_carry_pre", 32'(carry), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t1_req_drop", 32'(mem_req), 32'd0);
      check("t1_we_drop",  32'(mem_we),  32'd0);
      check("t1_pc0",      32'(pc),      32'd0);
      check("t1_acc0",     32'(acc),     32'd0);
      check("t1_carry0",   32'(carry),   32'd0);
      @(negedge clk);
      rst = 1'b1;
      #4;
      check("t1_idle_req", 32'(mem_req), 32'd0);
      tick();
      check("t1_fetch", 32'({mem_req, mem_we, mem_addr}), 32'h200);

      // Straight-line program, zero wait states.
      do_reset();
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tb_mem[0] = ins(3'd5, 8'h10); tb_mem[1] = ins(3'd2, 8'h11);
      tb_mem[2] = ins(3'd6, 8'h12); tb_mem[3] = ins(3'd0, 8'h00);
      tb_mem[8'h10] = 16'h0005; tb_mem[8'h11] = 16'h0003;
      run_prog(0, 50, "t2");
      check("t2_latency", 32'(halt_cyc - first_req), 32'd11);
      check("t2_store",   32'(tb_mem[8'h12]),        32'h0008);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_no_req", 32'(mem_req), 32'd0);
      end

      // Wait states: 3 in FETCH, 2 in MEM.
      do_reset();
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tb_mem[0] = ins(3'd5, 8'h10); tb_mem[8'h10] = 16'hBEEF;
      rdy_sel = 3;
      man_rdy = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #4;
      step(1'b0);
      check("t3_fetch", 32'({mem_req, mem_we, mem_addr}), 32'h200);
      wd0 = mem_wdata;
      for (int i = 0; i < 3; i++) begin
         step(i == 2);
         check("t3_fwait_bus", 32'({mem_req, mem_we, mem_addr}), 32'h200);
         check("t3_fwait_wd",  32'(mem_wdata), 32'(wd0));
         check("t3_fwait_pc",  32'(pc),        32'd0);
      end
      step(1'b0);
      check("t3_decode", 32'({mem_req, pc}), 32'h001);
      step(1'b0);
      check("t3_mem", 32'({mem_req, mem_we, mem_addr}), 32'h210);
      step(1'b0);
      check("t3_mwait1", 32'({mem_req, mem_we, mem_addr, acc}), 32'h2100000);
      step(1'b1);
      check("t3_mwait2", 32'({mem_req, mem_we, mem_addr, acc}), 32'h2100000);
      step(1'b0);
      check("t3_acc", 32'(acc), 32'hBEEF);
      check("t3_next_fetch", 32'({mem_req, pc}), 32'h101);

      // Branching and pc wrap.
      do_reset();
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tb_mem[0] = ins(3'd1, 8'h00); tb_mem[1] = ins(3'd0, 8'h00);
      tb_mem[2] = ins(3'd5, 8'h41); tb_mem[3] = ins(3'd1, 8'h00);
      tb_mem[4] = ins(3'd5, 8'h42); tb_mem[5] = ins(3'd7, 8'hFF);
      tb_mem[8'hFF] = ins(3'd1, 8'h00);
      tb_mem[8'h41] = 16'h0001; tb_mem[8'h42] = 16'h0000;
      run_prog(0, 50, "t4");
      check("t4_pc_wrap", 32'(pc), 32'h02);

      // ALU: ADD overflow, XOR and AND keep carry.
      do_reset();
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      tb_mem[0] = ins(3'd5, 8'h20); tb_mem[1] = ins(3'd2, 8'h21);
      tb_mem[2] = ins(3'd6, 8'h30); tb_mem[3] = ins(3'd4, 8'h22);
      tb_mem[4] = ins(3'd6, 8'h31); tb_mem[5] = ins(3'd3, 8'h23);
      tb_mem[6] = ins(3'd0, 8'h00);
      tb_mem[8'h20] = 16'hFFFF; tb_mem[8'h21] = 16'h0001;
      tb_mem[8'h22] = 16'h00F0; tb_mem[8'h23] = 16'h0030;
      tb_mem[8'h30] = 16'h5555; tb_mem[8'h31] = 16'h5555;
      run_prog(0, 50, "t5");
      check("t5_add_wrap", 32'(tb_mem[8'h30]), 32'h0000);
      check("t5_xor",      32'(tb_mem[8'h31]), 32'h00F0);
      check("t5_and",      32'(acc),           32'h0030);
      check("t5_carry",    32'(carry),         32'd1);

      // Halt is terminal regardless of ready activity.
      rdy_sel = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t6_halt_state", 32'({mem_req, halted, pc, acc}), 32'h1070030);
      end
      rst = 1'b0;
      #1;
      check("t6_unhalt", 32'(halted), 32'd0);

      // Random programs with random wait states.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int i = 0; i < 256; i++) tb_mem[i] = 16'($urandom);
         for (int i = 0; i < 32; i++)
            tb_mem[i] = ins(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         run_prog(1, 60, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc_risc_core.md
# acc_risc_core

Parametrised multicycle accumulator RISC core: a successor to the fixed-width accumulator processor. It replaces the fixed decoder, program counter, instruction register, accumulator and ALU with one controller FSM and a single memory port. Width, address space and memory wait states are all variable. It sits between the top-level test harness and a unified instruction/data memory, and talks to that memory through a req/ready handshake.

## Interface
- `DATA_W`, default 32: accumulator, instruction and memory word width. Must satisfy DATA_W ≥ ADDR_W + 3.
- `ADDR_W`, default 5: PC and operand address width. Memory depth is 2^ADDR_W words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write, 0 = read. Valid while `mem_req`=1.
- `mem_addr`  out  ADDR_W  transaction address.
- `mem_wdata`  out  DATA_W  write data, equal to `acc`.
- `mem_rdata`  in  DATA_W  read data, sampled on the edge where `mem_ready`=1.
- `mem_ready`  in  1  completes the current transaction. Ignored while `mem_req`=0.
- `pc`  out  ADDR_W  program counter.
- `acc`  out  DATA_W  accumulator.
- `carry`  out  1  carry-out of the last ADD.
- `halted`  out  1  core is in HALT.

## Operation
- Instruction word layout: opcode = bits [DATA_W-1:DATA_W-3]; operand address = bits [ADDR_W-1:0]; all other bits are ignored.
- Opcode set:
  - 0 HLT: halt.
  - 1 SKZ: if acc==0 then pc+=1.
  - 2 ADD: acc+=M[a], carry=carry-out.
  - 3 AND: acc&=M[a].
  - 4 XOR: acc^=M[a].
  - 5 LDA: acc=M[a].
  - 6 STA: M[a]=acc.
  - 7 JMP: pc=a.
- FSM states: IDLE, FETCH, DECODE, MEM, HALT.
  - IDLE: entered on reset. Moves to FETCH on the first edge after `rst` deasserts.
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=pc. On `mem_ready`: IR←mem_rdata, pc←pc+1, go to DECODE.
  - DECODE: no request.
    - HLT goes to HALT.
    - SKZ and JMP update pc and go to FETCH.
    - ADD, AND, XOR, LDA and STA go to MEM.
  - MEM: `mem_req`=1, `mem_addr`=IR operand, `mem_we`=(op==STA). On `mem_ready`: ALU ops and LDA update acc; go to FETCH.
  - HALT: terminal. `mem_req`=0. Left only via reset.
- Arithmetic:
  - ADD wraps modulo 2^DATA_W.
  - `carry` changes only on ADD completion.
  - AND, XOR and LDA leave `carry` unchanged.
- PC arithmetic wraps modulo 2^ADDR_W. This applies both to FETCH increment and to SKZ skip at pc = 2^ADDR_W−1.
- Handshake:
  - Once `mem_req` rises, `mem_we`, `mem_addr` and `mem_wdata` stay stable until the edge where `mem_ready`=1.
  - `mem_req` is never withdrawn early.
  - A zero-wait memory (`mem_ready` tied high) is legal.
- `mem_req`, `mem_we` and `halted` decode combinationally from the state register only. They have no combinational path from `mem_ready`.

## Timing
- Reset values: state=IDLE, pc=0, acc=0, IR=0, carry=0, mem_req=0, mem_we=0, mem_addr=0, halted=0.
- Reset asserted mid-transaction: all of the above apply immediately (asynchronously), and `mem_req` drops the same instant.
- First FETCH request appears one cycle after reset release.
- Cycles per instruction with zero wait states:
  - HLT, SKZ, JMP: 2 (FETCH + DECODE).
  - ADD, AND, XOR, LDA, STA: 3.
- Each wait cycle (`mem_ready`=0 while requesting) adds exactly one cycle. pc, acc and IR hold during wait cycles.
- `acc` and `carry` are visible the cycle after the MEM completion edge. `mem_wdata` for STA is the acc value at DECODE.
- `halted` rises the cycle after HLT is decoded.

## Structure
- Shared package `risc_pkg`:
  - opcode enum (HLT…JMP, 3-bit).
  - FSM state enum.
  - opcode field position constants.
- One sub-module, `acc_alu`: combinational. Inputs: opcode, acc, operand. Outputs: result, carry.
- The FSM, PC, IR and accumulator live in `acc_risc_core`.

## Test plan
All tests use DATA_W=16, ADDR_W=8.
- Reset: drop `rst` during MEM with `mem_req`=1 → `mem_req`=0, pc=0, acc=0 and carry=0 immediately. After release, IDLE for 1 cycle, then a FETCH with `mem_addr`=0x00.
- Program with ready tied high: LDA 0x10 (M=0x0005), ADD 0x11 (M=0x0003), STA 0x12, HLT → write of 0x0008 to 0x12. `halted`=1 exactly 11 cycles after the first FETCH, and `mem_req` stays 0 afterwards.
- Wait states: hold `mem_ready`=0 for 3 cycles in FETCH and 2 in MEM → addr, we and wdata stable throughout. pc increments once, and the instruction completes 5 cycles later than the zero-wait case.
- Branching:
  - SKZ with acc=0 skips the next word.
  - SKZ with acc=0x0001 does not skip.
  - JMP 0xFF, then SKZ with acc=0 at 0xFF → next fetch at address 0x01 (wrap).
- ALU: acc=0xFFFF, ADD M=0x0001 → acc=0x0000, carry=1. Then XOR M=0x00F0 → acc=0x00F0, carry still 1. Then AND M=0x0030 → 0x0030.
- Halt: after HLT, toggle `mem_ready` randomly for 20 cycles → no request, pc and acc frozen, `halted`=1 until `rst` is low.
